// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one ALU operand/select path among
// N_REQ requesters. The winner's operands are registered onto the ALU, the
// block waits SETTLE cycles for the result mux, then captures the result and
// pulses a one-hot ack for one cycle.
// Optional feature macro: ALU_ARB_OPCHECK_EN (illegal op codes 5..7 are
// rejected with an err pulse instead of being issued).
module alu_arbiter #(
  parameter int N_REQ  = 4,
  parameter int WIDTH  = 32,
  parameter int SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [3*N_REQ-1:0]     op_flat,
  input  logic [WIDTH*N_REQ-1:0] a_flat,
  input  logic [WIDTH*N_REQ-1:0] b_flat,
  input  logic [WIDTH-1:0]       alu_out,
  output logic [3:0]             alu_ctl,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       result,
  output logic                   busy,
  output logic                   err
);

  localparam int PTR_W = (N_REQ < 2) ? 1 : $clog2(N_REQ);
  localparam int CNT_W = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   win_q, win_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         ctl_q, ctl_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [N_REQ-1:0]   ack_q, ack_d;

  logic               grant_vld;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   ptr_nxt;
  logic [2:0]         op_g;
  logic [WIDTH-1:0]   a_g;
  logic [WIDTH-1:0]   b_g;
  logic               op_bad;

  // Round-robin search: first set req bit at or after ptr, wrapping upward
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!grant_vld && req[(int'(ptr_q) + k) % N_REQ]) begin
        grant_vld = 1'b1;
        grant_idx = PTR_W'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  assign op_g    = op_flat[3*int'(grant_idx) +: 3];
  assign a_g     = a_flat[WIDTH*int'(grant_idx) +: WIDTH];
  assign b_g     = b_flat[WIDTH*int'(grant_idx) +: WIDTH];
  assign ptr_nxt = (int'(grant_idx) == N_REQ-1) ? '0 : grant_idx + 1'b1;

`ifdef ALU_ARB_OPCHECK_EN
  logic err_q, err_d;
  assign op_bad = (op_g > 3'd4);
`else
  assign op_bad = 1'b0;
`endif

  // Next-state and datapath-load decisions for the IDLE/WAIT/DONE sequence
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    ctl_d   = ctl_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    ack_d   = '0;
`ifdef ALU_ARB_OPCHECK_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          ptr_d = ptr_nxt;
          win_d = grant_idx;
          if (op_bad) begin
            // Rejected op: ack immediately, leave ALU inputs and result alone
            ack_d   = {{(N_REQ-1){1'b0}}, 1'b1} << grant_idx;
            state_d = S_DONE;
`ifdef ALU_ARB_OPCHECK_EN
            err_d   = 1'b1;
`endif
          end else begin
            ctl_d   = {1'b0, op_g};
            a_d     = a_g;
            b_d     = b_g;
            cnt_d   = CNT_W'(SETTLE);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          res_d   = alu_out;
          ack_d   = {{(N_REQ-1){1'b0}}, 1'b1} << win_q;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      ctl_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      ack_q   <= '0;
`ifdef ALU_ARB_OPCHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      ack_q   <= ack_d;
`ifdef ALU_ARB_OPCHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign alu_ctl = ctl_q;
  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign result  = res_q;
  assign ack     = ack_q;
  assign busy    = (state_q != S_IDLE);
`ifdef ALU_ARB_OPCHECK_EN
  assign err     = err_q;
`else
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter (N_REQ=4, WIDTH=32, SETTLE=2).
// A behavioural result mux drives alu_out from alu_ctl/alu_a/alu_b:
// I0=a&b, I1=a|b, I2=a+b, I3=a-b, I4=a^b.
module tb_alu_arbiter;

  localparam int N = 4;
  localparam int W = 32;
  localparam int S = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [3*N-1:0] op_flat;
  logic [W*N-1:0] a_flat;
  logic [W*N-1:0] b_flat;
  logic [W-1:0]   alu_out;
  logic [3:0]     alu_ctl;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [N-1:0]   ack;
  logic [W-1:0]   result;
  logic           busy;
  logic           err;

  int n_checks = 0;
  int n_fail   = 0;

  alu_arbiter #(.N_REQ(N), .WIDTH(W), .SETTLE(S)) dut (
    .clk(clk), .reset(reset), .req(req), .op_flat(op_flat), .a_flat(a_flat),
    .b_flat(b_flat), .alu_out(alu_out), .alu_ctl(alu_ctl), .alu_a(alu_a),
    .alu_b(alu_b), .ack(ack), .result(result), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mux_model(logic [3:0] c, logic [W-1:0] a, logic [W-1:0] b);
    case (c)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a - b;
      4'd4:    return a ^ b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_out = mux_model(alu_ctl, alu_a, alu_b);

  task automatic set_op(input int i, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    op_flat[3*i +: 3] = op;
    a_flat[W*i +: W]  = a;
    b_flat[W*i +: W]  = b;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; op_flat = '0; a_flat = '0; b_flat = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if ({alu_ctl, alu_a, alu_b, ack, result, busy, err} !== '0) begin
        n_fail++;
        $display("FAIL reset_idle c%0d: ctl=%h a=%h b=%h ack=%b res=%h busy=%b err=%b, required all 0",
                 c, alu_ctl, alu_a, alu_b, ack, result, busy, err);
      end
    end
  endtask

  task automatic test_single();
    set_op(0, 3'd2, 32'd5, 32'd7);
    req = 4'b0001;
    @(negedge clk);
    n_checks++;
    if ({busy, alu_ctl, alu_a, alu_b, ack} !== {1'b1, 4'd2, 32'd5, 32'd7, 4'b0000}) begin
      n_fail++;
      $display("FAIL single_issue: busy=%b ctl=%h a=%h b=%h ack=%b, required 1 2 5 7 0000", busy, alu_ctl, alu_a, alu_b, ack);
    end
    @(negedge clk);
    n_checks++;
    if ({busy, alu_ctl, ack} !== {1'b1, 4'd2, 4'b0000}) begin
      n_fail++;
      $display("FAIL single_settle: busy=%b ctl=%h ack=%b, required 1 2 0000", busy, alu_ctl, ack);
    end
    @(negedge clk);
    n_checks++;
    if (ack !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_ack: got %b, required 0001", ack);
    end
    n_checks++;
    if (result !== 32'h0000_000C) begin
      n_fail++;
      $display("FAIL single_result: got %h, required 0000000c", result);
    end
    req = 4'b0000;
    @(negedge clk);
    n_checks++;
    if ({ack, busy, result} !== {4'b0000, 1'b0, 32'h0000_000C}) begin
      n_fail++;
      $display("FAIL single_release: ack=%b busy=%b res=%h, required 0000 0 0000000c", ack, busy, result);
    end
  endtask

  task automatic test_round_robin();
    logic [W-1:0] exp_res [4];
    logic [3:0]   oh;
    int           e;
    exp_res[0] = 32'd2;   // 10 & 6
    exp_res[1] = 32'd23;  // 20 | 3
    exp_res[2] = 32'd35;  // 30 + 5
    exp_res[3] = 32'd25;  // 40 - 15
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    set_op(0, 3'd0, 32'd10, 32'd6);
    set_op(1, 3'd1, 32'd20, 32'd3);
    set_op(2, 3'd2, 32'd30, 32'd5);
    set_op(3, 3'd3, 32'd40, 32'd15);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      e  = g % 4;
      oh = 4'b0001 << e;
      @(negedge clk);
      n_checks++;
      if ({ack, busy, alu_ctl} !== {4'b0000, 1'b1, 4'(e)}) begin
        n_fail++;
        $display("FAIL rr_issue g%0d: ack=%b busy=%b ctl=%h, required 0000 1 %0d", g, ack, busy, alu_ctl, e);
      end
      @(negedge clk);
      n_checks++;
      if (ack !== 4'b0000) begin
        n_fail++;
        $display("FAIL rr_wait g%0d: ack=%b, required 0000", g, ack);
      end
      @(negedge clk);
      n_checks++;
      if (ack !== oh) begin
        n_fail++;
        $display("FAIL rr_ack g%0d: got %b, required %b", g, ack, oh);
      end
      n_checks++;
      if (result !== exp_res[e]) begin
        n_fail++;
        $display("FAIL rr_result g%0d: got %h, required %h", g, result, exp_res[e]);
      end
      @(negedge clk);
      n_checks++;
      if (ack !== 4'b0000) begin
        n_fail++;
        $display("FAIL rr_release g%0d: ack=%b, required 0000", g, ack);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_reset_mid();
    req = 4'b0010;
    @(negedge clk);
    n_checks++;
    if ({busy, alu_ctl} !== {1'b1, 4'd1}) begin
      n_fail++;
      $display("FAIL mid_issue: busy=%b ctl=%h, required 1 1", busy, alu_ctl);
    end
    reset = 1'b1;
    req   = 4'b0000;
    @(negedge clk);
    n_checks++;
    if ({alu_ctl, alu_a, alu_b, ack, result, busy, err} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_clear: ctl=%h a=%h b=%h ack=%b res=%h busy=%b err=%b, required all 0",
               alu_ctl, alu_a, alu_b, ack, result, busy, err);
    end
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({ack, busy} !== 5'b0) begin
        n_fail++;
        $display("FAIL mid_no_ack c%0d: ack=%b busy=%b, required 0000 0", c, ack, busy);
      end
    end
    req = 4'b0010;
    @(negedge clk);
    n_checks++;
    if ({busy, alu_ctl, alu_a} !== {1'b1, 4'd1, 32'd20}) begin
      n_fail++;
      $display("FAIL mid_reissue: busy=%b ctl=%h a=%h, required 1 1 00000014", busy, alu_ctl, alu_a);
    end
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({ack, result} !== {4'b0010, 32'd23}) begin
      n_fail++;
      $display("FAIL mid_rerequest_ack: ack=%b res=%h, required 0010 00000017", ack, result);
    end
    req = 4'b0000;
    @(negedge clk);
    n_checks++;
    if ({ack, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL mid_release: ack=%b busy=%b, required 0000 0", ack, busy);
    end
  endtask

  task automatic test_back_to_back();
    req = 4'b0100;
    repeat (2) @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({ack, result} !== {4'b0100, 32'd35}) begin
      n_fail++;
      $display("FAIL b2b_ack1: ack=%b res=%h, required 0100 00000023", ack, result);
    end
    @(negedge clk);
    n_checks++;
    if ({ack, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: ack=%b busy=%b, required 0000 0", ack, busy);
    end
    set_op(2, 3'd2, 32'd100, 32'd23);
    @(negedge clk);
    n_checks++;
    if ({busy, alu_a, alu_b, result} !== {1'b1, 32'd100, 32'd23, 32'd35}) begin
      n_fail++;
      $display("FAIL b2b_reissue: busy=%b a=%h b=%h res=%h, required 1 00000064 00000017 00000023", busy, alu_a, alu_b, result);
    end
    @(negedge clk);
    n_checks++;
    if ({ack, result} !== {4'b0000, 32'd35}) begin
      n_fail++;
      $display("FAIL b2b_hold: ack=%b res=%h, required 0000 00000023", ack, result);
    end
    @(negedge clk);
    n_checks++;
    if ({ack, result} !== {4'b0100, 32'd123}) begin
      n_fail++;
      $display("FAIL b2b_ack2: ack=%b res=%h, required 0100 0000007b", ack, result);
    end
    req = 4'b0000;
    @(negedge clk);
    n_checks++;
    if ({ack, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL b2b_release: ack=%b busy=%b, required 0000 0", ack, busy);
    end
  endtask

  task automatic test_illegal_op();
    set_op(1, 3'd6, 32'd1, 32'd2);
    req = 4'b0010;
`ifdef ALU_ARB_OPCHECK_EN
    @(negedge clk);
    n_checks++;
    if ({ack, err, result, alu_ctl} !== {4'b0010, 1'b1, 32'd123, 4'd2}) begin
      n_fail++;
      $display("FAIL opchk_err: ack=%b err=%b res=%h ctl=%h, required 0010 1 0000007b 2", ack, err, result, alu_ctl);
    end
    req = 4'b0000;
    @(negedge clk);
    n_checks++;
    if ({ack, err, busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL opchk_release: ack=%b err=%b busy=%b, required 0000 0 0", ack, err, busy);
    end
    set_op(2, 3'd2, 32'd7, 32'd8);
    req = 4'b0110;
    @(negedge clk);
    n_checks++;
    if ({busy, alu_ctl, alu_a} !== {1'b1, 4'd2, 32'd7}) begin
      n_fail++;
      $display("FAIL opchk_next_issue: busy=%b ctl=%h a=%h, required 1 2 00000007", busy, alu_ctl, alu_a);
    end
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({ack, result} !== {4'b0100, 32'd15}) begin
      n_fail++;
      $display("FAIL opchk_next_grant: ack=%b res=%h, required 0100 0000000f", ack, result);
    end
    req = 4'b0000;
    @(negedge clk);
`else
    @(negedge clk);
    n_checks++;
    if ({busy, alu_ctl, err} !== {1'b1, 4'd6, 1'b0}) begin
      n_fail++;
      $display("FAIL op_raw_issue: busy=%b ctl=%h err=%b, required 1 6 0", busy, alu_ctl, err);
    end
    @(negedge clk);
    n_checks++;
    if ({ack, err} !== 5'b0) begin
      n_fail++;
      $display("FAIL op_raw_wait: ack=%b err=%b, required 0000 0", ack, err);
    end
    @(negedge clk);
    n_checks++;
    if ({ack, err} !== {4'b0010, 1'b0}) begin
      n_fail++;
      $display("FAIL op_raw_ack: ack=%b err=%b, required 0010 0", ack, err);
    end
    req = 4'b0000;
    @(negedge clk);
    n_checks++;
    if ({ack, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL op_raw_release: ack=%b busy=%b, required 0000 0", ack, busy);
    end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_reset_mid();
    test_back_to_back();
    test_illegal_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
